dff_share_arbiter: RTL and testbench
====================================

# dff_share_arbiter

Round-robin write arbiter for one shared WIDTH-bit D-flip-flop register. Up to NREQ requesters compete to load the register. Each winner receives a one-cycle grant, then the register captures that requester's data, then the requester receives a one-cycle acknowledge. The block owns the register and drives its true output `q` and complement `qb` to downstream logic.

## Interface
- `WIDTH`, 8: width of the shared register and of each requester's data slice.
- `NREQ`, 4: number of requesters, from 2 to 2**IDW.
- `IDW`, 2: width of the `owner` index.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low reset. Low clears all state immediately, independent of `clk`.
- `req`  input  NREQ: per-requester write request, level-sensitive.
- `wdata`  input  NREQ*WIDTH: requester i's data is `wdata[i*WIDTH +: WIDTH]`.
- `gnt`  output  NREQ: one-hot grant, registered, high only in GRANT.
- `ack`  output  1: write-complete pulse, registered, high only in ACK.
- `owner`  output  IDW: index of the last requester granted.
- `busy`  output  1: high whenever the state is not IDLE.
- `q`  output  WIDTH: shared register contents.
- `qb`  output  WIDTH: always `~q`, with no extra latency.

## Operation
- FSM has three states: IDLE, GRANT and ACK. It is encoded as 2 bits, and the unused encoding returns to IDLE.
- IDLE:
  - If `req` is nonzero, select winner w by round-robin and go to GRANT.
  - Otherwise stay in IDLE.
- Round-robin search:
  - Starts at `(ptr+1) mod NREQ` and ascends with wrap-around.
  - The first requester found with `req` high is the winner.
  - `ptr` holds the index of the last winner.
- On entry to GRANT:
  - `gnt[w]` = 1 and `owner` = w.
  - `ptr` = w, updated on the same edge.
- GRANT lasts exactly one cycle:
  - On the edge that ends GRANT, `q` loads `wdata` slice w. The state goes to ACK.
  - The write commits even if `req[w]` drops during GRANT.
  - `req` of other requesters is ignored in GRANT.
- ACK lasts exactly one cycle:
  - `ack` = 1 and `gnt` = 0. `q` already holds the new value.
  - The next state is always IDLE.
- Requester side: after seeing `ack`, a requester should drop `req` within one cycle.
  - If it keeps `req` high, it is re-arbitrated with the lowest priority.
  - No deadlock and no starvation: every requester with `req` high continuously is served within NREQ transactions.
- `q` changes only at the GRANT→ACK edge or at reset. It holds its value in every other state.
- Reset (`reset` = 0), asserted at any time including mid-transaction:
  - State = IDLE, `q` = 0, `qb` = all ones.
  - `gnt` = 0, `ack` = 0, `busy` = 0, `owner` = 0.
  - `ptr` = NREQ-1, so requester 0 has top priority first.
  - Any in-flight write is dropped.
- After `reset` deasserts, the first arbitration happens on the first rising edge at which `reset` is high.

## Timing
- `req` is sampled at edge E0. GRANT is visible in the cycle after E0.
- `q` updates at edge E1, and `ack` is high in the following cycle.
- At edge E2 the state returns to IDLE. The earliest next grant is visible after edge E3.
- Request-to-ack latency is 2 cycles. Peak throughput is one write per 3 cycles.
- `wdata[w]` must be stable on the edge that ends GRANT. It is don't-care otherwise.
- `gnt`, `ack`, `busy` and `owner` come straight from flops, with no combinational path from the inputs.
- `qb` is combinational from `q` only.
- Reset assertion clears the outputs asynchronously, within the same cycle and without waiting for a clock edge.

## Test plan
- **Reset values:** hold `reset` = 0 for 3 cycles with `req` = 4'b1111 → `q` = 8'h00, `qb` = 8'hFF, `gnt` = 0, `ack` = 0, `busy` = 0, `owner` = 0 throughout.
- **Single requester:** `req` = 4'b0100 with slice 2 = 8'hA5, released on `ack` →
  - `gnt` = 4'b0100 for 1 cycle, `owner` = 2.
  - Next cycle: `ack` = 1, `q` = 8'hA5, `qb` = 8'h5A.
  - Then IDLE, with `busy` = 0.
- **Fairness:** `req` = 4'b1111 held continuously →
  - Grant order is 0, 1, 2, 3, 0, with one grant every 3 cycles.
  - `q` tracks each slice in turn: 8'h11, 8'h22, 8'h33, 8'h44.
- **Wrap-around priority:** after requester 3 is served, set `req` = 4'b1001 → requester 0 wins before requester 3 is served again.
- **Drop during grant:** deassert `req[1]` in the GRANT cycle, with slice 1 = 8'h3C → `q` still becomes 8'h3C and `ack` pulses once.
- **Reset mid-operation:** pulse `reset` low asynchronously during GRANT, with slice = 8'hFF →
  - `q` stays 8'h00 and `gnt` clears immediately.
  - `ack` never pulses.
  - After release, requester 0 has top priority.

Source files
------------

// File: rtl/dff_share_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register.
// Each transaction is a one-cycle grant, then the register load, then a one-cycle acknowledge.
module dff_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic                    ack,
  output logic [IDW-1:0]          owner,
  output logic                    busy,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qb
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    ACK   = 2'b10
  } state_t;

  state_t         state, state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           found;
  int             idx;

  // Search starts just after the last winner, so a winner drops to lowest priority.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = GRANT;
      GRANT:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // All handshake outputs are flops so downstream logic sees no input-to-output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt   <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      owner <= '0;
      ptr   <= IDW'(NREQ - 1);
      q     <= '0;
    end else begin
      gnt  <= '0;
      ack  <= 1'b0;
      busy <= (state_next != IDLE);
      if (state == IDLE && found) begin
        gnt   <= NREQ'(1) << win;
        owner <= win;
        ptr   <= win;
      end
      if (state == GRANT) begin
        q   <= wdata[int'(owner)*WIDTH +: WIDTH];
        ack <= 1'b1;
      end
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level round-robin model.
module tb_dff_share_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  ack;
  logic [IDW-1:0]        owner;
  logic                  busy;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qb;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr;
  logic [WIDTH-1:0] model_q;

  dff_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .owner (owner),
    .busy  (busy),
    .q     (q),
    .qb    (qb)
  );

  always #5 clk = ~clk;

  // Reference rule: first requesting index after the last winner, wrapping.
  function automatic int rr_winner(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Drives one transaction starting from an idle negedge and captures what the
  // DUT shows in the grant, ack and following idle cycles.
  task automatic run_txn(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d,
                         input bit drop,
                         output logic [NREQ-1:0] g_gnt, output logic [IDW-1:0] g_owner,
                         output logic [WIDTH-1:0] g_q, output logic g_busy,
                         output logic a_ack, output logic [NREQ-1:0] a_gnt,
                         output logic [WIDTH-1:0] a_q, output logic [WIDTH-1:0] a_qb,
                         output logic i_busy, output logic i_ack);
    req   = r;
    wdata = d;
    @(negedge clk);
    g_gnt = gnt; g_owner = owner; g_q = q; g_busy = busy;
    if (drop) req = r & ~(NREQ'(1) << g_owner);
    @(negedge clk);
    a_ack = ack; a_gnt = gnt; a_q = q; a_qb = qb;
    @(negedge clk);
    i_busy = busy; i_ack = ack;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 4'b1111;
    wdata = $urandom;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({q, qb, gnt, ack, busy, owner} !== {8'h00, 8'hFF, 4'b0000, 1'b0, 1'b0, 2'd0}) begin
        n_fail++;
        $display("[TB] FAIL reset_values cycle %0d: got q=%h qb=%h gnt=%b ack=%b busy=%b owner=%0d, expected q=00 qb=ff gnt=0000 ack=0 busy=0 owner=0",
                 c, q, qb, gnt, ack, busy, owner);
      end
    end
    req       = '0;
    reset     = 1'b1;
    model_ptr = NREQ - 1;
    model_q   = '0;
  endtask

  task automatic test_idle();
    req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, gnt, ack} !== 6'b0) begin
        n_fail++;
        $display("[TB] FAIL idle_quiet: got busy=%b gnt=%b ack=%b, expected all 0", busy, gnt, ack);
      end
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] g_gnt, a_gnt;
    logic [IDW-1:0]  g_owner;
    logic [WIDTH-1:0] g_q, a_q, a_qb;
    logic g_busy, a_ack, i_busy, i_ack;
    int order [4] = '{0, 1, 2, 3};
    logic [WIDTH-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int n = 0; n < 4; n++) begin
      run_txn(4'b1111, 32'h44332211, 1'b0, g_gnt, g_owner, g_q, g_busy,
              a_ack, a_gnt, a_q, a_qb, i_busy, i_ack);
      n_checks++;
      if (g_gnt !== (NREQ'(1) << order[n]) || g_owner !== IDW'(order[n])) begin
        n_fail++;
        $display("[TB] FAIL fair_order #%0d: got gnt=%b owner=%0d, expected requester %0d", n, g_gnt, g_owner, order[n]);
      end
      n_checks++;
      if (a_q !== vals[n] || a_ack !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL fair_data #%0d: got q=%h ack=%b, expected q=%h ack=1", n, a_q, a_ack, vals[n]);
      end
      model_ptr = order[n];
      model_q   = vals[n];
    end
  endtask

  task automatic test_wraparound();
    logic [NREQ-1:0] g_gnt, a_gnt;
    logic [IDW-1:0]  g_owner;
    logic [WIDTH-1:0] g_q, a_q, a_qb;
    logic g_busy, a_ack, i_busy, i_ack;
    int exp_w [2] = '{0, 3};
    for (int n = 0; n < 2; n++) begin
      run_txn(4'b1001, 32'hC3B2A190, 1'b0, g_gnt, g_owner, g_q, g_busy,
              a_ack, a_gnt, a_q, a_qb, i_busy, i_ack);
      n_checks++;
      if (g_gnt !== (NREQ'(1) << exp_w[n])) begin
        n_fail++;
        $display("[TB] FAIL wrap_order #%0d: got gnt=%b, expected requester %0d", n, g_gnt, exp_w[n]);
      end
      model_ptr = exp_w[n];
    end
    model_q = 8'hC3;
    req = '0;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g_gnt, a_gnt;
    logic [IDW-1:0]  g_owner;
    logic [WIDTH-1:0] g_q, a_q, a_qb;
    logic g_busy, a_ack, i_busy, i_ack;
    run_txn(4'b0100, {8'h77, 8'hA5, 8'h66, 8'h55}, 1'b0, g_gnt, g_owner, g_q, g_busy,
            a_ack, a_gnt, a_q, a_qb, i_busy, i_ack);
    req = '0;
    n_checks++;
    if (g_gnt !== 4'b0100 || g_owner !== 2'd2 || g_busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_grant: got gnt=%b owner=%0d busy=%b, expected gnt=0100 owner=2 busy=1", g_gnt, g_owner, g_busy);
    end
    n_checks++;
    if (g_q !== model_q) begin
      n_fail++;
      $display("[TB] FAIL single_q_hold: got q=%h during grant, expected %h", g_q, model_q);
    end
    n_checks++;
    if (a_ack !== 1'b1 || a_gnt !== 4'b0000 || a_q !== 8'hA5 || a_qb !== 8'h5A) begin
      n_fail++;
      $display("[TB] FAIL single_ack: got ack=%b gnt=%b q=%h qb=%h, expected ack=1 gnt=0000 q=a5 qb=5a", a_ack, a_gnt, a_q, a_qb);
    end
    n_checks++;
    if (i_busy !== 1'b0 || i_ack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_idle: got busy=%b ack=%b, expected 0 0", i_busy, i_ack);
    end
    model_ptr = 2;
    model_q   = 8'hA5;
  endtask

  task automatic test_drop_during_grant();
    logic [NREQ-1:0] g_gnt, a_gnt;
    logic [IDW-1:0]  g_owner;
    logic [WIDTH-1:0] g_q, a_q, a_qb;
    logic g_busy, a_ack, i_busy, i_ack;
    run_txn(4'b0010, {8'h01, 8'h02, 8'h3C, 8'h04}, 1'b1, g_gnt, g_owner, g_q, g_busy,
            a_ack, a_gnt, a_q, a_qb, i_busy, i_ack);
    n_checks++;
    if (g_gnt !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL drop_grant: got gnt=%b, expected 0010", g_gnt);
    end
    n_checks++;
    if (a_q !== 8'h3C || a_ack !== 1'b1 || i_ack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drop_commit: got q=%h ack=%b next_ack=%b, expected q=3c ack=1 next_ack=0", a_q, a_ack, i_ack);
    end
    model_ptr = 1;
    model_q   = 8'h3C;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g_gnt, a_gnt, r;
    logic [IDW-1:0]  g_owner;
    logic [WIDTH-1:0] g_q, a_q, a_qb, exp_q;
    logic [NREQ*WIDTH-1:0] d;
    logic g_busy, a_ack, i_busy, i_ack;
    int w;
    for (int n = 0; n < 24; n++) begin
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      d = $urandom;
      w = rr_winner(model_ptr, r);
      exp_q = d[w*WIDTH +: WIDTH];
      run_txn(r, d, 1'($urandom_range(0, 1)), g_gnt, g_owner, g_q, g_busy,
              a_ack, a_gnt, a_q, a_qb, i_busy, i_ack);
      n_checks++;
      if (g_gnt !== (NREQ'(1) << w) || g_owner !== IDW'(w) || g_q !== model_q) begin
        n_fail++;
        $display("[TB] FAIL rand_grant #%0d req=%b: got gnt=%b owner=%0d q=%h, expected requester %0d q=%h",
                 n, r, g_gnt, g_owner, g_q, w, model_q);
      end
      n_checks++;
      if (a_ack !== 1'b1 || a_q !== exp_q || a_qb !== ~exp_q || a_gnt !== '0) begin
        n_fail++;
        $display("[TB] FAIL rand_ack #%0d: got ack=%b q=%h qb=%h gnt=%b, expected ack=1 q=%h qb=%h gnt=0",
                 n, a_ack, a_q, a_qb, a_gnt, exp_q, ~exp_q);
      end
      model_ptr = w;
      model_q   = exp_q;
      if ($urandom_range(0, 2) == 0) begin
        req = '0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || q !== model_q) begin
          n_fail++;
          $display("[TB] FAIL rand_gap #%0d: got busy=%b q=%h, expected busy=0 q=%h", n, busy, q, model_q);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] g_gnt, a_gnt;
    logic [IDW-1:0]  g_owner;
    logic [WIDTH-1:0] g_q, a_q, a_qb;
    logic g_busy, a_ack, i_busy, i_ack;
    int ack_seen = 0;
    req   = 4'b0001;
    wdata = {8'h00, 8'h00, 8'h00, 8'hFF};
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL mid_pre_grant: got gnt=%b, expected 0001", gnt);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({gnt, q, qb, busy, owner} !== {4'b0000, 8'h00, 8'hFF, 1'b0, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL mid_async_clear: got gnt=%b q=%h qb=%h busy=%b owner=%0d, expected 0000 00 ff 0 0",
               gnt, q, qb, busy, owner);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ack !== 1'b0) ack_seen++;
      if (c == 1) req = '0;
      if (c == 2) reset = 1'b1;
    end
    n_checks++;
    if (ack_seen != 0 || q !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL mid_no_ack: got %0d ack cycles q=%h, expected 0 ack cycles q=00", ack_seen, q);
    end
    model_ptr = NREQ - 1;
    model_q   = '0;
    run_txn(4'b1111, 32'h44332211, 1'b0, g_gnt, g_owner, g_q, g_busy,
            a_ack, a_gnt, a_q, a_qb, i_busy, i_ack);
    n_checks++;
    if (g_gnt !== (NREQ'(1) << rr_winner(model_ptr, 4'b1111)) || a_q !== 8'h11) begin
      n_fail++;
      $display("[TB] FAIL mid_after_release: got gnt=%b q=%h, expected gnt=0001 q=11", g_gnt, a_q);
    end
    req = '0;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    wdata = '0;
    test_reset();
    test_idle();
    test_fairness();
    test_wraparound();
    test_single();
    test_drop_during_grant();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
